// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader that sits in front of the instruction memory of the
// single-cycle datapath. It receives a byte stream on a valid/ready handshake,
// assembles little-endian 32-bit instruction words and writes each one through
// the instruction-memory write port. The datapath PC is held in reset until the
// whole program has been written.
//
// Stream format:  N (word count, one byte), then 4*N payload bytes, byte 0 of
// each word first. With LOADER_CHECKSUM_EN defined, the payload is followed by
// one byte that must equal the XOR of all payload bytes.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHECK state).
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction-memory write strobe (one-cycle pulse)
//   imem_addr    word address of the write
//   imem_wdata   instruction word to write
//   core_reset   active-high datapath reset, low only in DONE
//   done         program loaded and core released
//   error        load aborted (sticky until reset or restart)
//   restart      in DONE or ERROR: start a new load
//   words_loaded number of words written during this load
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_reset,
   output logic                  done,
   output logic                  error,
   input  logic                  restart,
   output logic [ADDR_WIDTH:0]   words_loaded
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_HEADER,
      S_LOAD,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic [ADDR_WIDTH:0]   word_cnt;      // N latched from the header
   logic [1:0]            byte_idx;      // position of the next byte in its word
   logic [23:0]           byte_shift;    // bytes 0..2 of the word being assembled
   logic [ADDR_WIDTH:0]   words_inc;
   logic                  last_word;
   logic                  hdr_too_big;
   logic                  accept;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            cksum;         // running XOR of payload bytes
`endif

   // words_loaded doubles as the word index: it counts completed writes, so it
   // always equals the address of the word currently being assembled. It is
   // one bit wider than the address so that N = DEPTH never wraps.
   assign words_inc   = words_loaded + (ADDR_WIDTH+1)'(1);
   assign last_word   = (words_inc == word_cnt);
   assign hdr_too_big = (32'(in_data) > 32'(DEPTH));
   assign accept      = in_valid & in_ready;

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_HEADER;
      end else begin
         state <= state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and state-decoded outputs. The transition conditions use
   // in_valid directly: in_ready is 1 in every state that leaves on a byte, so
   // this equals a handshake and avoids feeding in_ready back into itself.
   // --------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first so no path
   // leaves a signal unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      in_ready   = 1'b0;
      core_reset = 1'b1;
      done       = 1'b0;
      error      = 1'b0;

      unique case (state)
         S_HEADER: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (in_data == 8'd0) begin
                  state_nxt = S_DONE;      // empty program: nothing to check
               end else if (hdr_too_big) begin
                  state_nxt = S_ERROR;
               end else begin
                  state_nxt = S_LOAD;
               end
            end
         end

         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid && (byte_idx == 2'd3) && last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = S_CHECK;
`else
               state_nxt = S_DONE;
`endif
            end
         end

`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = (in_data == cksum) ? S_DONE : S_ERROR;
            end
         end
`endif

         S_DONE: begin
            done       = 1'b1;
            core_reset = 1'b0;
            if (restart) begin
               state_nxt = S_HEADER;
            end
         end

         S_ERROR: begin
            error = 1'b1;
            if (restart) begin
               state_nxt = S_HEADER;
            end
         end

         default: begin
            state_nxt = S_HEADER;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Word assembly and registered write port.
   // The write for a word is issued on the edge after its byte 3 is accepted;
   // the loader keeps in_ready high meanwhile, so the next word's byte 0 can be
   // taken in the same cycle the write strobe is visible.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
         word_cnt     <= '0;
         byte_idx     <= '0;
         byte_shift   <= '0;
`ifdef LOADER_CHECKSUM_EN
         cksum        <= '0;
`endif
      end else begin
         imem_we <= 1'b0;

         if ((state == S_HEADER) && accept) begin
            // Truncation is safe: an N that does not fit goes to ERROR.
            word_cnt     <= (ADDR_WIDTH+1)'(in_data);
            byte_idx     <= '0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            cksum        <= '0;
`endif
         end

         if ((state == S_LOAD) && accept) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            cksum    <= cksum ^ in_data;
`endif
            if (byte_idx == 2'd3) begin
               imem_we      <= 1'b1;
               imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
               imem_wdata   <= {in_data, byte_shift};
               words_loaded <= words_inc;
            end else begin
               // Shift in from the top: after bytes 0..2 the oldest byte sits
               // in [7:0], giving little-endian order when byte 3 is prepended.
               byte_shift <= {in_data, byte_shift[23:8]};
            end
         end

         if (((state == S_DONE) || (state == S_ERROR)) && restart) begin
            words_loaded <= '0;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Scoreboard bench for program_loader. Stimulus tasks describe each load as a
// header plus a list of payload bytes; the reference model turns that list
// into the expected sequence of memory writes (address, little-endian word,
// running word count) and pushes it into a queue. An independent monitor pops
// and compares on every imem_we pulse. Status outputs are checked by the
// stimulus at the points where the stream format defines them.
// -----------------------------------------------------------------------------
module tb_program_loader;

   localparam int ADDR_WIDTH = 5;
   localparam int DEPTH      = 1 << ADDR_WIDTH;

   logic                  clk;
   logic                  reset;
   logic                  in_valid;
   logic [7:0]            in_data;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  core_reset;
   logic                  done;
   logic                  error;
   logic                  restart;
   logic [ADDR_WIDTH:0]   words_loaded;

   program_loader #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_reset   (core_reset),
      .done         (done),
      .error        (error),
      .restart      (restart),
      .words_loaded (words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard of expected writes
   // ---------------------------------------------------------------------------
   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cnt;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", imem_we, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", imem_addr, mon_e.addr);
            check("write_data", imem_wdata, mon_e.data);
            check("write_count", words_loaded, mon_e.cnt);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers. All of them start and end 1 time unit after a rising
   // edge, so inputs never change near the active edge.
   // ---------------------------------------------------------------------------
   task automatic send_byte(input logic [7:0] b, output int waited);
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 64) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with restart toggled at random; only used while the loader is
   // in HEADER or LOAD, where restart must have no effect.
   task automatic gap(input int cycles);
      in_valid = 1'b0;
      repeat (cycles) begin
         restart = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
      end
      restart = 1'b0;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(posedge clk);
      #1;
      restart = 1'b0;
      @(negedge clk);
      check("restart_in_ready", in_ready, 1);
      check("restart_done", done, 0);
      check("restart_error", error, 0);
      check("restart_core_reset", core_reset, 1);
      check("restart_words", words_loaded, 0);
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // One complete load: model, stimulus, status checks, stray-byte check,
   // restart. gap_max = 0 means continuous valid with no stall allowed.
   // ---------------------------------------------------------------------------
   task automatic run_load(input logic [7:0] hdr, input logic [7:0] pay[$],
                           input int gap_max, input bit bad_cks);
      int          n;
      int          waited;
      bit          too_big;
      logic [7:0]  x;
      logic [31:0] w;
      wr_t         e;
      bit          expect_err;

      n       = int'(hdr);
      too_big = (n > DEPTH);
      x       = 8'h00;

      // Reference model: word i is bytes 4i..4i+3, least significant first.
      if (!too_big) begin
         for (int i = 0; i < n; i++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
               w = w + (32'(pay[4*i+j]) << (8*j));
               x = x ^ pay[4*i+j];
            end
            e.addr = i;
            e.data = w;
            e.cnt  = i + 1;
            exp_q.push_back(e);
         end
      end

      if (gap_max > 0) gap($urandom_range(0, gap_max));
      send_byte(hdr, waited);

      if (too_big || n == 0) begin
         in_valid = 1'b0;
         @(negedge clk);
         check("hdr_done", done, (n == 0));
         check("hdr_error", error, too_big);
         check("hdr_core_reset", core_reset, too_big);
         check("hdr_words", words_loaded, 0);
         expect_err = too_big;
      end else begin
         if (gap_max == 0) check("hdr_no_stall", waited, 0);
         for (int k = 0; k < 4*n; k++) begin
            if (gap_max > 0) gap($urandom_range(0, gap_max));
            send_byte(pay[k], waited);
            if (gap_max == 0) check("payload_no_stall", waited, 0);
         end
         in_valid = 1'b0;
         @(negedge clk);
         check("last_write_strobe", imem_we, 1);
         check("last_words", words_loaded, n);
`ifdef LOADER_CHECKSUM_EN
         check("check_in_ready", in_ready, 1);
         check("check_done", done, 0);
         check("check_core_reset", core_reset, 1);
         @(posedge clk);
         #1;
         send_byte(bad_cks ? (x ^ 8'h01) : x, waited);
         in_valid = 1'b0;
         @(negedge clk);
         check("cks_done", done, !bad_cks);
         check("cks_error", error, bad_cks);
         check("cks_core_reset", core_reset, bad_cks);
         check("cks_words", words_loaded, n);
         expect_err = bad_cks;
`else
         check("final_done", done, 1);
         check("final_core_reset", core_reset, 0);
         check("final_error", error, 0);
         check("final_in_ready", in_ready, 0);
         expect_err = 1'b0;
`endif
      end

      // Extra bytes in DONE/ERROR must not be consumed; a stray write would be
      // caught by the monitor.
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         check("end_in_ready", in_ready, 0);
         check("end_error_sticky", error, expect_err);
         check("end_done_sticky", done, !expect_err);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("writes_pending", exp_q.size(), 0);
      do_restart();
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   logic [7:0] pay[$];
   int         waited;
   int         n_rand;

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_core_reset", core_reset, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_we", imem_we, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_words", words_loaded, 0);
      @(posedge clk);
      #1;

      // Two-word program with continuous valid.
      pay.delete();
      pay.push_back(8'h13); pay.push_back(8'h00); pay.push_back(8'h00); pay.push_back(8'h00);
      pay.push_back(8'h93); pay.push_back(8'h00); pay.push_back(8'h10); pay.push_back(8'h00);
      run_load(8'h02, pay, 0, 1'b0);

      // Header one past DEPTH.
      pay.delete();
      run_load(8'(DEPTH + 1), pay, 0, 1'b0);

      // Partial word interrupted by reset is discarded.
      send_byte(8'h01, waited);
      send_byte(8'h13, waited);
      send_byte(8'h00, waited);
      in_valid = 1'b0;
      reset    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_words", words_loaded, 0);
      check("midrst_core_reset", core_reset, 1);
      @(posedge clk);
      #1;
      pay.delete();
      pay.push_back(8'h13); pay.push_back(8'h00); pay.push_back(8'h00); pay.push_back(8'h00);
      run_load(8'h01, pay, 0, 1'b0);

      // Empty program.
      pay.delete();
      run_load(8'h00, pay, 0, 1'b0);

      // Single word with good and bad checksum (checksum only matters when the
      // feature is built in).
      pay.delete();
      pay.push_back(8'h13); pay.push_back(8'h00); pay.push_back(8'h00); pay.push_back(8'h00);
      run_load(8'h01, pay, 0, 1'b0);
      run_load(8'h01, pay, 0, 1'b1);

      // Randomised loads: first one fills the whole memory with continuous
      // valid, the rest use random gaps and random restart noise.
      for (int r = 0; r < 7; r++) begin
         n_rand = (r == 0) ? DEPTH : $urandom_range(1, 9);
         pay.delete();
         for (int k = 0; k < 4*n_rand; k++) pay.push_back(8'($urandom));
         run_load(8'(n_rand), pay, (r == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
      end

      // Random oversized headers.
      for (int r = 0; r < 3; r++) begin
         pay.delete();
         run_load(8'($urandom_range(DEPTH + 1, 255)), pay, 2, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time stage directly upstream of the single-cycle datapath's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word through the instruction memory write port.
- Holds the datapath in reset until the whole program is written, then releases it.

Parameters:
ADDR_WIDTH, 5, instruction-memory word-address width; DEPTH = 2**ADDR_WIDTH words (default 32).

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
in_valid  input  1  upstream byte valid
in_data  input  8  upstream byte
in_ready  output  1  loader can accept a byte this cycle
imem_we  output  1  instruction memory write strobe, one-cycle pulse
imem_addr  output  ADDR_WIDTH  word address of write
imem_wdata  output  32  instruction word to write
core_reset  output  1  active-high reset for datapath PC; high while not DONE
done  output  1  program loaded and core released
error  output  1  load aborted, sticky until reset/restart
restart  input  1  in DONE or ERROR: begin a new load
words_loaded  output  ADDR_WIDTH+1  count of words written this load

Behaviour:
- Handshake: a byte transfers on a rising edge with in_valid=1 and in_ready=1. Upstream holds in_data stable while in_valid=1 and in_ready=0.
- Reset (reset=0 at edge) clears all state in any state, mid-word included:
  - state=HEADER, in_ready=1 (the cycle after reset is released), imem_we=0, imem_addr=0, imem_wdata=0.
  - core_reset=1, done=0, error=0, words_loaded=0.
  - Partial words are discarded. Memory already written is not erased.
- States HEADER, LOAD, CHECK (macro only), DONE, ERROR:
  - HEADER, in_ready=1: the accepted byte is N, the word count.
    - N=0: go to DONE (no CHECK, even with macro).
    - N>DEPTH: go to ERROR.
    - Otherwise: latch N, clear the byte index and word index, go to LOAD.
  - LOAD, in_ready=1: byte k of a word (k=0..3) goes to bits [8k+7:8k].
    - On acceptance of byte 3, the registered write fires on the next edge: imem_we=1 for exactly one cycle, imem_addr=word index, imem_wdata=assembled word, words_loaded increments in the same cycle.
    - The next byte may be accepted in that same cycle (no bubble).
    - After byte 3 of word N-1: go to CHECK (macro) or DONE.
  - DONE: in_ready=0, done=1.
    - core_reset falls in the first DONE cycle. For N>0 that is the cycle the final imem_we is high, so the write is visible before the first fetch.
  - ERROR: in_ready=0, error=1, core_reset=1, no further writes.
  - restart=1 in DONE or ERROR: next state HEADER, core_reset=1, done=0, error=0, words_loaded=0. restart is ignored in other states.
- Simultaneous events: reset has priority over restart and over handshakes. An in_valid byte arriving while in_ready=0 is not consumed.
- Loading N=DEPTH writes addresses 0..DEPTH-1. The word index never wraps.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte the loader enters CHECK, in_ready=1, and accepts one byte.
  - If that byte equals the XOR of all 4N payload bytes, go to DONE; otherwise go to ERROR.
  - Words already written stay written; core_reset remains 1 on mismatch.
- Undefined: no CHECK state; DONE follows the last payload byte directly. Any extra byte is not accepted (in_ready=0).

Test Plan:
- Reset held low 3 cycles, then released -> in_ready=1, core_reset=1, done=0, error=0, imem_we never pulsed.
- Bytes 02, 13,00,00,00, 93,00,10,00 with continuous valid -> imem_we at addr0 data 00000013, addr1 data 00100093 (back-to-back, no stall), words_loaded=2, done=1, core_reset=0 the same cycle as second write.
- Header 21 (33 > DEPTH 32) -> error=1, in_ready=0, no imem_we, core_reset=1; then restart=1 -> HEADER, error=0.
- Header 01, bytes 13,00, reset low, then 01,13,00,00,00 -> single write addr0 data 00000013; the partial word before reset is never written.
- Header 00 -> done=1 next cycle, words_loaded=0, no write.
- Macro defined: 01, 13,00,00,00, checksum 13 -> done=1; repeat with checksum 12 -> error=1, core_reset stays 1.
